// File: rtl/oram_pattern_requester.sv
// Bring-up initiator: writes an address-derived pattern to every ORAM block, then reads each back and checks it.
// One handshake per cycle with no bubbles; valids/ready come from registered state only, so backend stalls simply hold the current beat.
module oram_pattern_requester #(
    parameter int ORAMU         = 32,
    parameter int ORAMB         = 512,
    parameter int FEDWidth      = 512,
    parameter int NumValidBlock = 1024,
    parameter int ErrWidth      = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    output logic [1:0]          ORAMCommand,
    output logic [ORAMU-1:0]    ORAMPAddr,
    output logic                ORAMCommandValid,
    input  logic                ORAMCommandReady,
    output logic [FEDWidth-1:0] ORAMDataIn,
    output logic                ORAMDataInValid,
    input  logic                ORAMDataInReady,
    input  logic [FEDWidth-1:0] ORAMDataOut,
    input  logic                ORAMDataOutValid,
    output logic                ORAMDataOutReady,
    output logic                Busy,
    output logic                Done,
    output logic [ErrWidth-1:0] ErrorCount,
    output logic [ORAMU-1:0]    FirstErrorAddr,
    output logic                Error
);

    localparam int BeatsPerBlock = ORAMB / FEDWidth;
    localparam int ChunksPerBeat = FEDWidth / ORAMU;
    localparam int BeatW         = (BeatsPerBlock > 1) ? $clog2(BeatsPerBlock) : 1;

    localparam logic [BeatW-1:0]    LastBeat    = BeatW'(BeatsPerBlock - 1);
    localparam logic [BeatW-1:0]    BeatOne     = BeatW'(1);
    localparam logic [ORAMU-1:0]    LastAddr    = ORAMU'(NumValidBlock - 1);
    localparam logic [ORAMU-1:0]    AddrOne     = ORAMU'(1);
    localparam logic [ORAMU-1:0]    ChunkStride = ORAMU'(ChunksPerBeat);
    localparam logic [ErrWidth-1:0] ErrMax      = '1;
    localparam logic [ErrWidth-1:0] ErrOne      = ErrWidth'(1);

    localparam logic [1:0] BECMD_Append = 2'd1;
    localparam logic [1:0] BECMD_Read   = 2'd2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_CMD  = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_CMD  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]          state;
    logic [ORAMU-1:0]    addr;
    logic [BeatW-1:0]    beat;
    logic [FEDWidth-1:0] pattern;
    logic                lastBeat;
    logic                lastAddr;
    logic                mismatch;

    // Shared by write generation and read-back compare: both walk the same addr/beat sequence.
    always_comb begin
        pattern = '0;
        for (int j = 0; j < ChunksPerBeat; j++) begin
            pattern[j*ORAMU +: ORAMU] = addr + ORAMU'(beat) * ChunkStride + ORAMU'(j);
        end
    end

    assign lastBeat = (beat == LastBeat);
    assign lastAddr = (addr == LastAddr);
    assign mismatch = (ORAMDataOut != pattern);

    assign ORAMCommandValid = (state == WR_CMD) || (state == RD_CMD);
    assign ORAMCommand      = (state == WR_CMD) ? BECMD_Append :
                              (state == RD_CMD) ? BECMD_Read   : 2'd0;
    assign ORAMPAddr        = addr;
    assign ORAMDataInValid  = (state == WR_DATA);
    assign ORAMDataIn       = ORAMDataInValid ? pattern : '0;
    assign ORAMDataOutReady = (state == RD_DATA);
    assign Busy             = (state != IDLE) && (state != DONE);
    assign Done             = (state == DONE);
    assign Error            = (ErrorCount != '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            addr           <= '0;
            beat           <= '0;
            ErrorCount     <= '0;
            FirstErrorAddr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state          <= WR_CMD;
                        addr           <= '0;
                        beat           <= '0;
                        ErrorCount     <= '0;
                        FirstErrorAddr <= '0;
                    end
                end
                WR_CMD: begin
                    if (ORAMCommandReady) state <= WR_DATA;
                end
                WR_DATA: begin
                    if (ORAMDataInReady) begin
                        if (lastBeat) begin
                            beat <= '0;
                            if (lastAddr) begin
                                addr  <= '0;
                                state <= RD_CMD;
                            end else begin
                                addr  <= addr + AddrOne;
                                state <= WR_CMD;
                            end
                        end else begin
                            beat <= beat + BeatOne;
                        end
                    end
                end
                RD_CMD: begin
                    if (ORAMCommandReady) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (ORAMDataOutValid) begin
                        // A zero count means no error has been seen since Start.
                        if (mismatch) begin
                            if (ErrorCount != ErrMax) ErrorCount <= ErrorCount + ErrOne;
                            if (ErrorCount == '0) FirstErrorAddr <= addr;
                        end
                        if (lastBeat) begin
                            beat <= '0;
                            if (lastAddr) begin
                                addr  <= '0;
                                state <= DONE;
                            end else begin
                                addr  <= addr + AddrOne;
                                state <= RD_CMD;
                            end
                        end else begin
                            beat <= beat + BeatOne;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oram_pattern_requester.sv
// Bench for oram_pattern_requester: memory responder with optional stalls/corruption, scoreboard of commands and write beats.
module tb_oram_pattern_requester;

    localparam int U   = 32;
    localparam int B   = 512;
    localparam int FW  = 128;
    localparam int NB  = 16;
    localparam int EW  = 2;
    localparam int BPB = B / FW;
    localparam int CPB = FW / U;
    localparam logic [1:0] CMD_APPEND = 2'd1;
    localparam logic [1:0] CMD_READ   = 2'd2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic [1:0]    ORAMCommand;
    logic [U-1:0]  ORAMPAddr;
    logic          ORAMCommandValid;
    logic          ORAMCommandReady;
    logic [FW-1:0] ORAMDataIn;
    logic          ORAMDataInValid;
    logic          ORAMDataInReady;
    logic [FW-1:0] ORAMDataOut;
    logic          ORAMDataOutValid;
    logic          ORAMDataOutReady;
    logic          Busy;
    logic          Done;
    logic [EW-1:0] ErrorCount;
    logic [U-1:0]  FirstErrorAddr;
    logic          Error;

    always #5 Clock = ~Clock;

    oram_pattern_requester #(
        .ORAMU(U), .ORAMB(B), .FEDWidth(FW), .NumValidBlock(NB), .ErrWidth(EW)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .ORAMCommand(ORAMCommand), .ORAMPAddr(ORAMPAddr),
        .ORAMCommandValid(ORAMCommandValid), .ORAMCommandReady(ORAMCommandReady),
        .ORAMDataIn(ORAMDataIn), .ORAMDataInValid(ORAMDataInValid), .ORAMDataInReady(ORAMDataInReady),
        .ORAMDataOut(ORAMDataOut), .ORAMDataOutValid(ORAMDataOutValid), .ORAMDataOutReady(ORAMDataOutReady),
        .Busy(Busy), .Done(Done), .ErrorCount(ErrorCount),
        .FirstErrorAddr(FirstErrorAddr), .Error(Error)
    );

    typedef struct packed {logic [1:0] cmd; logic [U-1:0] addr;} cmd_t;
    typedef struct {int addr; int beat;} rd_t;

    int   errors = 0;
    int   checks = 0;
    int   mode   = 0;
    bit   stall  = 0;
    int   expErr;
    int   expFirst;
    cmd_t expCmdQ[$];
    logic [FW-1:0] expWrQ[$];
    rd_t  readQ[$];
    int   wrAddrQ[$];
    int   wrBeat = 0;
    logic [FW-1:0] mem [NB][BPB];
    rd_t  curRd;
    bit   prevCmdStall = 0;
    bit   prevWrStall  = 0;
    cmd_t prevCmd;
    logic [FW-1:0] prevWr;
    cmd_t expCmd;
    logic [FW-1:0] expWr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    function automatic logic [FW-1:0] refBeat(input int a, input int b);
        logic [FW-1:0] v;
        for (int j = 0; j < CPB; j++) v[j*U +: U] = 32'(a + b * CPB + j);
        return v;
    endfunction

    function automatic bit corrupts(input int a, input int b);
        if (mode == 2) return 1'b1;
        if (mode == 1) return ((a == 5) || (a == 9)) && (b == 0);
        return 1'b0;
    endfunction

    // Memory responder: drives readies and read beats at negedge, then books the handshakes due at the next posedge.
    initial begin
        ORAMCommandReady = 1'b0;
        ORAMDataInReady  = 1'b0;
        ORAMDataOutValid = 1'b0;
        ORAMDataOut      = '0;
        forever begin
            @(negedge Clock);
            ORAMCommandReady = stall ? ($urandom_range(3) != 0) : 1'b1;
            ORAMDataInReady  = stall ? ($urandom_range(3) != 0) : 1'b1;
            if (readQ.size() > 0 && (!stall || $urandom_range(3) != 0)) begin
                curRd = readQ[0];
                ORAMDataOutValid = 1'b1;
                ORAMDataOut = mem[curRd.addr][curRd.beat] ^ (corrupts(curRd.addr, curRd.beat) ? 128'd1 : 128'd0);
            end else begin
                ORAMDataOutValid = 1'b0;
                ORAMDataOut = {$urandom, $urandom, $urandom, $urandom};
            end
            #2;
            if (!Reset) begin
                if (ORAMCommandValid && ORAMCommandReady && ORAMPAddr < NB) begin
                    if (ORAMCommand == CMD_APPEND) wrAddrQ.push_back(int'(ORAMPAddr));
                    else for (int b = 0; b < BPB; b++) readQ.push_back('{int'(ORAMPAddr), b});
                end
                if (ORAMDataInValid && ORAMDataInReady && wrAddrQ.size() > 0) begin
                    mem[wrAddrQ[0]][wrBeat] = ORAMDataIn;
                    wrBeat++;
                    if (wrBeat == BPB) begin
                        wrBeat = 0;
                        void'(wrAddrQ.pop_front());
                    end
                end
                if (ORAMDataOutValid && ORAMDataOutReady && readQ.size() > 0) void'(readQ.pop_front());
            end
        end
    end

    // Monitor: pops the scoreboard on every command / write-beat handshake and checks hold-under-stall.
    initial begin
        forever begin
            @(negedge Clock);
            #3;
            if (Reset) begin
                prevCmdStall = 0;
                prevWrStall  = 0;
            end else begin
                if (prevCmdStall)
                    check("cmd_hold", {ORAMCommandValid, ORAMCommand, ORAMPAddr}, {1'b1, prevCmd});
                if (prevWrStall)
                    check("data_hold", {ORAMDataInValid, ORAMDataIn}, {1'b1, prevWr});
                if (ORAMCommandValid && ORAMCommandReady) begin
                    if (expCmdQ.size() == 0) failNow("cmd_unexpected");
                    else begin
                        expCmd = expCmdQ.pop_front();
                        check("cmd", {ORAMCommand, ORAMPAddr}, expCmd);
                    end
                end
                if (ORAMDataInValid && ORAMDataInReady) begin
                    if (expWrQ.size() == 0) failNow("wrbeat_unexpected");
                    else begin
                        expWr = expWrQ.pop_front();
                        check("wrbeat", ORAMDataIn, expWr);
                    end
                end
                prevCmdStall = ORAMCommandValid && !ORAMCommandReady;
                prevCmd      = {ORAMCommand, ORAMPAddr};
                prevWrStall  = ORAMDataInValid && !ORAMDataInReady;
                prevWr       = ORAMDataIn;
            end
        end
    end

    task automatic startRun(input int m, input bit s);
        bit found;
        mode = m;
        stall = s;
        for (int a = 0; a < NB; a++) begin
            expCmdQ.push_back({CMD_APPEND, U'(a)});
            for (int b = 0; b < BPB; b++) expWrQ.push_back(refBeat(a, b));
        end
        for (int a = 0; a < NB; a++) expCmdQ.push_back({CMD_READ, U'(a)});
        expErr = 0;
        expFirst = 0;
        found = 0;
        for (int a = 0; a < NB; a++)
            for (int b = 0; b < BPB; b++)
                if (corrupts(a, b)) begin
                    if (!found) expFirst = a;
                    found = 1;
                    expErr++;
                end
        if (expErr > (1 << EW) - 1) expErr = (1 << EW) - 1;
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        check("busy_after_start", Busy, 1);
        check("cmdvalid_after_start", ORAMCommandValid, 1);
        check("done_cleared", Done, 0);
        check("errcnt_cleared", ErrorCount, 0);
        check("firsterr_cleared", FirstErrorAddr, 0);
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        while (!Done && cyc < 3000) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
        if (!Done) failNow("done_timeout");
    endtask

    task automatic endChecks();
        check("done", Done, 1);
        check("busy_idle", Busy, 0);
        check("errcount", ErrorCount, expErr);
        check("error_flag", Error, expErr != 0);
        check("first_err_addr", FirstErrorAddr, expFirst);
        check("cmds_left", expCmdQ.size(), 0);
        check("wrbeats_left", expWrQ.size(), 0);
        check("reads_left", readQ.size(), 0);
    endtask

    int cyc;

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        check("rst_cmdvalid", ORAMCommandValid, 0);
        check("rst_datainvalid", ORAMDataInValid, 0);
        check("rst_dataoutready", ORAMDataOutReady, 0);
        check("rst_busy_done", {Busy, Done, Error}, 0);
        check("rst_outputs", {ErrorCount, FirstErrorAddr, ORAMPAddr, ORAMCommand}, 0);
        check("rst_datain", ORAMDataIn, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // Ideal responder: exact run length and clean status.
        startRun(0, 0);
        waitDone(cyc);
        check("run_cycles_ideal", cyc, NB * 2 * (1 + BPB));
        endChecks();

        // Stalled run, beat 0 of blocks 5 and 9 corrupted, Start poked mid-write.
        startRun(1, 1);
        cyc = 0;
        do begin
            @(negedge Clock);
            #4;
            cyc++;
        end while (!ORAMDataInValid && cyc < 200);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        check("start_ignored_busy", Busy, 1);
        waitDone(cyc);
        endChecks();
        check("pattern_a2_b1_c0", mem[2][1][31:0], 32'h6);

        // Restart straight from DONE with every read beat corrupted: counter saturates.
        startRun(2, 1);
        waitDone(cyc);
        endChecks();

        // Asynchronous reset while reading back.
        startRun(0, 1);
        cyc = 0;
        do begin
            @(negedge Clock);
            #1;
            cyc++;
        end while (!ORAMDataOutReady && cyc < 3000);
        if (!ORAMDataOutReady) failNow("reach_rd_data");
        Reset = 1'b1;
        expCmdQ.delete();
        expWrQ.delete();
        readQ.delete();
        wrAddrQ.delete();
        wrBeat = 0;
        #1;
        check("arst_valids", {ORAMCommandValid, ORAMDataInValid, ORAMDataOutReady}, 0);
        check("arst_status", {Busy, Done, Error, ErrorCount}, 0);
        check("arst_addr_cmd", {FirstErrorAddr, ORAMPAddr, ORAMCommand}, 0);
        check("arst_datain", ORAMDataIn, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // Clean pass after the abort.
        startRun(0, 0);
        waitDone(cyc);
        check("run_cycles_after_reset", cyc, NB * 2 * (1 + BPB));
        endChecks();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
